fetch_stage: RTL and testbench

Instruction fetch stage of the RV32I core. Owns the program counter, issues word addresses to the synchronous instruction memory, and presents each returned instruction with its PC and a valid flag to decode, where the immediate generator and register file consume it. Handles boot from a reset vector, back-pressure from decode, and PC redirects from execute (taken branches, JAL/JALR). Invalid slots carry a canonical NOP so decode logic always sees a legal encoding.

---
 rtl/fetch_stage_pkg.sv | 40 ++++
 rtl/fetch_stage.sv | 81 ++++++++
 tb/tb_fetch_stage.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_pkg.sv
//==============================================================================
// Module      : fetch_stage_pkg
// Description : Shared RV32I core constants: boot vector, canonical NOP,
//               base opcodes and fetch-stage state encoding.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package fetch_stage_pkg;

    localparam logic [31:0] c_RESET_PC   = 32'h4000_0000;
    localparam logic [31:0] c_NOP        = 32'h0000_0013;  // addi x0, x0, 0
    localparam logic [31:0] c_INST_BYTES = 32'd4;
    localparam logic [31:0] c_WORD_MASK  = 32'hFFFF_FFFC;

    // RV32I base opcodes, shared with the decoder and immediate generator
    localparam logic [6:0] c_OPC_LUI      = 7'b0110111;
    localparam logic [6:0] c_OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] c_OPC_JAL      = 7'b1101111;
    localparam logic [6:0] c_OPC_JALR     = 7'b1100111;
    localparam logic [6:0] c_OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] c_OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] c_OPC_STORE    = 7'b0100011;
    localparam logic [6:0] c_OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] c_OPC_OP       = 7'b0110011;
    localparam logic [6:0] c_OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] c_OPC_SYSTEM   = 7'b1110011;

    typedef enum logic [0:0] {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } fetch_state_e;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & c_WORD_MASK;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_stage.sv
//==============================================================================
// Module      : fetch_stage
// Description : RV32I instruction fetch: PC ownership, synchronous imem
//               addressing, stall hold and execute-stage redirects.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = c_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_valid,
    output logic [31:0] fetch_count
);

    fetch_state_e r_state;
    logic [31:0]  r_f_pc;
    logic [31:0]  r_fetch_count;

    logic [31:0]  w_imem_addr;
    logic [31:0]  w_seq_pc;
    logic         w_f_valid;
    logic         w_inst_valid;
    logic         w_accept;

    assign w_f_valid    = (r_state == ST_RUN);
    // The word arriving during a redirect belongs to the wrong path.
    assign w_inst_valid = w_f_valid & ~redirect_valid;
    assign w_accept     = w_inst_valid & ~stall;
    assign w_seq_pc     = r_f_pc + c_INST_BYTES;

    always_comb begin
        w_imem_addr = w_seq_pc;
        if (rst) begin
            w_imem_addr = RESET_PC;
        end else if (redirect_valid) begin
            w_imem_addr = word_align(redirect_pc);
        end else if ((r_state == ST_BOOT) || stall) begin
            // Re-read the current word so it is still on imem_rdata next cycle.
            w_imem_addr = r_f_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_BOOT;
            r_f_pc        <= RESET_PC;
            r_fetch_count <= '0;
        end else begin
            r_f_pc <= w_imem_addr;
            case (r_state)
                ST_BOOT: r_state <= ST_RUN;
                ST_RUN:  r_state <= ST_RUN;
                default: r_state <= ST_BOOT;
            endcase
            if (w_accept) begin
                r_fetch_count <= r_fetch_count + 32'd1;
            end
        end
    end

    assign imem_addr   = w_imem_addr;
    assign inst        = w_inst_valid ? imem_rdata : c_NOP;
    assign inst_pc     = r_f_pc;
    assign inst_valid  = w_inst_valid;
    assign fetch_count = r_fetch_count;

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
//==============================================================================
// Module      : tb_fetch_stage
// Description : Directed self-checking bench for fetch_stage with a
//               one-deep fetch scoreboard and synchronous imem model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_fetch_stage;

    localparam logic [31:0] c_RESET_PC = 32'h4000_0000;
    localparam logic [31:0] c_NOP      = 32'h0000_0013;
    localparam logic [31:0] c_FIRST    = 32'h0010_0093;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_valid;
    logic [31:0] fetch_count;

    fetch_stage #(
        .RESET_PC (c_RESET_PC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_valid     (inst_valid),
        .fetch_count    (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == c_RESET_PC) return c_FIRST;
        return {a[29:0], 2'b11} ^ 32'h5A5A_0000;
    endfunction

    always @(posedge clk) imem_rdata <= mem_word(imem_addr);

    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
        logic        valid;
    } sb_t;

    sb_t         sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] m_count  = '0;
    logic        last_r, last_s, last_ev;
    logic [31:0] cnt_snap;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, compare the slot now presented against the
    // scoreboard, and push the word being requested for the next cycle.
    task automatic drive(input logic r, input logic s, input logic rv, input logic [31:0] rpc);
        sb_t         e;
        logic [31:0] exp_addr;
        logic        ev;
        logic        have;
        rst = r; stall = s; redirect_valid = rv; redirect_pc = rpc;
        #1;
        ev   = 1'b0;
        have = (sb.size() > 0);
        e    = '{pc: c_RESET_PC, word: c_NOP, valid: 1'b0};
        if (have) begin
            e  = sb.pop_front();
            ev = e.valid & ~rv;
            check("sb_inst_pc", inst_pc, e.pc);
            check("sb_inst_valid", {31'b0, inst_valid}, {31'b0, ev});
            check("sb_inst", inst, ev ? e.word : c_NOP);
            check("sb_fetch_count", fetch_count, m_count);
        end
        if (r)                      exp_addr = c_RESET_PC;
        else if (rv)                exp_addr = {rpc[31:2], 2'b00};
        else if (!e.valid || s)     exp_addr = e.pc;
        else                        exp_addr = e.pc + 32'd4;
        if (have || r) check("sb_imem_addr", imem_addr, exp_addr);
        sb.push_back('{pc: exp_addr, word: mem_word(exp_addr), valid: !r});
        last_r = r; last_s = s; last_ev = ev;
    endtask

    task automatic tick();
        @(posedge clk);
        if (last_r)                 m_count = '0;
        else if (last_ev && !last_s) m_count = m_count + 32'd1;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;

        // Reset state
        drive(1, 0, 0, 0); tick();
        drive(1, 0, 0, 0);
        check("rst_imem_addr", imem_addr, c_RESET_PC);
        check("rst_inst_pc", inst_pc, c_RESET_PC);
        check("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
        check("rst_inst", inst, c_NOP);
        check("rst_fetch_count", fetch_count, 32'd0);
        tick();

        // Boot then first instruction
        drive(0, 0, 0, 0);
        check("boot_valid", {31'b0, inst_valid}, 32'd0);
        check("boot_inst", inst, c_NOP);
        check("boot_addr", imem_addr, c_RESET_PC);
        tick();
        drive(0, 0, 0, 0);
        check("first_inst", inst, c_FIRST);
        check("first_pc", inst_pc, 32'h4000_0000);
        check("first_valid", {31'b0, inst_valid}, 32'd1);
        tick();
        drive(0, 0, 0, 0);
        check("second_pc", inst_pc, 32'h4000_0004);
        tick();

        // Stall three cycles at 0x4000_0008
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 0, 0);
            check("stall_pc", inst_pc, 32'h4000_0008);
            check("stall_inst", inst, mem_word(32'h4000_0008));
            check("stall_addr", imem_addr, 32'h4000_0008);
            check("stall_count", fetch_count, 32'd2);
            tick();
        end
        drive(0, 0, 0, 0);
        check("unstall_addr", imem_addr, 32'h4000_000C);
        tick();
        drive(0, 0, 0, 0);
        check("resume_pc", inst_pc, 32'h4000_000C);
        check("resume_count", fetch_count, 32'd3);
        tick();

        // Redirect at 0x4000_0010 to unaligned target
        drive(0, 0, 1, 32'h4000_0103);
        check("redir_pc_now", inst_pc, 32'h4000_0010);
        check("redir_kill", {31'b0, inst_valid}, 32'd0);
        check("redir_addr", imem_addr, 32'h4000_0100);
        tick();
        drive(0, 0, 0, 0);
        check("redir_target_pc", inst_pc, 32'h4000_0100);
        check("redir_target_valid", {31'b0, inst_valid}, 32'd1);
        tick();

        // Redirect together with stall
        cnt_snap = fetch_count;
        drive(0, 1, 1, 32'h4000_0200);
        check("rs_kill", {31'b0, inst_valid}, 32'd0);
        check("rs_addr", imem_addr, 32'h4000_0200);
        tick();
        drive(0, 0, 0, 0);
        check("rs_target_pc", inst_pc, 32'h4000_0200);
        check("rs_count_frozen", fetch_count, cnt_snap);
        tick();

        // Back-to-back redirects
        drive(0, 0, 1, 32'h4000_0300); tick();
        drive(0, 0, 1, 32'h4000_0400);
        check("b2b_kill", {31'b0, inst_valid}, 32'd0);
        check("b2b_pc", inst_pc, 32'h4000_0300);
        tick();
        drive(0, 0, 0, 0);
        check("b2b_target_pc", inst_pc, 32'h4000_0400);
        tick();

        // PC wrap
        drive(0, 0, 1, 32'hFFFF_FFFC); tick();
        drive(0, 0, 0, 0);
        check("wrap_pc", inst_pc, 32'hFFFF_FFFC);
        check("wrap_addr", imem_addr, 32'h0000_0000);
        tick();
        drive(0, 0, 0, 0);
        check("wrap_next_pc", inst_pc, 32'h0000_0000);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 0); tick();
        end

        // Reset mid-stream with redirect and stall asserted
        drive(1, 1, 1, 32'h1234_5678);
        check("rst_mid_addr", imem_addr, c_RESET_PC);
        tick();
        drive(0, 0, 0, 0);
        check("rst_mid_count", fetch_count, 32'd0);
        check("rst_mid_valid", {31'b0, inst_valid}, 32'd0);
        check("rst_mid_pc", inst_pc, c_RESET_PC);
        tick();
        drive(0, 0, 0, 0);
        check("rst_mid_first", inst, c_FIRST);
        tick();

        // Redirect during BOOT
        drive(1, 0, 0, 0); tick();
        drive(0, 1, 1, 32'h4000_0500);
        check("boot_redir_addr", imem_addr, 32'h4000_0500);
        tick();
        drive(0, 0, 0, 0);
        check("boot_redir_pc", inst_pc, 32'h4000_0500);
        check("boot_redir_valid", {31'b0, inst_valid}, 32'd1);
        tick();

        // Stall during BOOT
        drive(1, 0, 0, 0); tick();
        drive(0, 1, 0, 0);
        check("boot_stall_addr", imem_addr, c_RESET_PC);
        tick();
        drive(0, 0, 0, 0);
        check("boot_stall_inst", inst, c_FIRST);
        check("boot_stall_valid", {31'b0, inst_valid}, 32'd1);
        tick();
        drive(0, 0, 0, 0); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
